apb_rr_master: RTL and testbench

Round-robin APB3 master that shares one APB memory slave among NUM_REQ local requesters. It arbitrates pending requests and runs the winner's APB3 SETUP/ACCESS transfer, waiting on pready. It returns read data and a per-requester completion pulse. It sits between the processing engines and the APB memory slave, and is the only driver of that slave's psel/penable/pwrite/paddr/pwdata.

---
 rtl/apb_rr_pkg.sv | 19 +
 rtl/apb_rr_master_rr_picker.sv | 32 +++
 rtl/apb_rr_master.sv | 128 ++++++++++++
 tb/tb_apb_rr_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// Shared types for the round-robin APB3 master.
// FSM state encoding and pointer-width helper.
package apb_rr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam int REQ_MAX = 8;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int PTR_W_MAX = ptr_w(REQ_MAX);

endpackage

// File: rtl/apb_rr_master_rr_picker.sv
// Round-robin picker: first eligible index at or after ptr, wrapping.
// Returns both a one-hot grant and the binary index.
module rr_picker
   import apb_rr_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  elig_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o
);

   always_comb begin
      logic found;
      int   j;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!found && elig_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB3 master sharing one slave among NUM_REQ requesters.
// Optional ACCESS timeout abort: define APB_RR_TIMEOUT_EN.
module apb_rr_master
   import apb_rr_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          err,
   output logic                          psel,
   output logic                          penable,
   output logic                          pwrite,
   output logic [ADDR_WIDTH-1:0]         paddr,
   output logic [DATA_WIDTH-1:0]         pwdata,
   input  logic [DATA_WIDTH-1:0]         prdata,
   input  logic                          pready
);

   localparam int PW = ptr_w(NUM_REQ);

   state_e             state_q;
   logic [PW-1:0]      ptr_q;
   logic [PW-1:0]      win_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic [PW-1:0]      gidx;
   logic [PW-1:0]      ptr_d;
   logic               tmo;

   // done is still high in the cycle after completion, masking that requester
   assign elig  = req & ~done;
   assign ptr_d = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);

   rr_picker #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt),
      .idx_o  (gidx)
   );

`ifdef APB_RR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] cnt_q;

   assign tmo = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         done    <= '0;
         rdata   <= '0;
         err     <= 1'b0;
      end else begin
         done <= '0;
         err  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (|elig) begin
                  win_q   <= gidx;
                  gnt_q   <= gnt;
                  pwrite  <= req_write[gidx];
                  paddr   <= req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
                  pwdata  <= req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                  psel    <= 1'b1;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state_q <= ACCESS;
            end
            ACCESS: begin
               if (pready || tmo) begin
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  done    <= gnt_q;
                  err     <= ~pready;
                  if (!pready) begin
                     rdata <= '0;
                  end else if (!pwrite) begin
                     rdata <= prdata;
                  end
                  ptr_q   <= ptr_d;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a simple APB memory slave model.
// Table-driven single transfers plus contention, wait, reset and timeout sequences.
module tb_apb_rr_master;

   logic       pclk = 1'b0;
   logic       presetn = 1'b0;
   logic [1:0] req = '0;
   logic [1:0] req_write = '0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic [1:0] done;
   logic [3:0] rdata;
   logic       err;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [3:0] paddr;
   logic [3:0] pwdata;
   logic [3:0] prdata;
   logic       pready;

   int total = 0;
   int bad = 0;

   logic [3:0] mem [16];
   int wcnt = 0;
   int kwait = 1;

   always #5 pclk = ~pclk;

   apb_rr_master #(
      .NUM_REQ        (2),
      .ADDR_WIDTH     (4),
      .DATA_WIDTH     (4),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready)
   );

   // Slave raises pready kwait cycles after the first ACCESS cycle
   assign pready = psel & penable & (wcnt >= kwait);
   assign prdata = mem[paddr];

   always @(posedge pclk) begin
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic xfer(input int idx, input logic wr, input logic [3:0] a,
                       input logic [3:0] wd, input int k,
                       output int lat, output logic [3:0] rd,
                       output logic er, output logic [1:0] dn,
                       output logic stable, output int pen);
      logic [3:0] a0, w0;
      logic cap;
      kwait = k;
      req_write[idx] = wr;
      req_addr[idx*4 +: 4] = a;
      req_wdata[idx*4 +: 4] = wd;
      req[idx] = 1'b1;
      lat = 0; rd = '0; er = 1'b0; dn = '0;
      stable = 1'b1; cap = 1'b0; pen = 0;
      a0 = '0; w0 = '0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge pclk); #1;
         if (penable) pen++;
         if (psel) begin
            if (!cap) begin
               a0 = paddr; w0 = pwdata; cap = 1'b1;
            end else if (paddr !== a0 || pwdata !== w0) begin
               stable = 1'b0;
            end
         end
         if (|done) begin
            lat = c; rd = rdata; er = err; dn = done;
            break;
         end
      end
      req[idx] = 1'b0;
      @(posedge pclk); #1;
   endtask

   typedef struct {
      int         idx;
      logic       wr;
      logic [3:0] addr;
      logic [3:0] wd;
      int         k;
      logic [3:0] exp_rd;
      int         exp_lat;
   } vec_t;

   vec_t vt [6];

   task automatic do_reset();
      presetn = 1'b0;
      req = '0;
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
      @(posedge pclk); #1;
   endtask

   initial begin
      int lat, pen, gap, ngap, seen;
      logic [3:0] rd;
      logic er, st;
      logic [1:0] dn;
      int ord [6];
      int cnt [2];
      logic prev_psel;

      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      mem[3] = 4'hA;

      vt[0] = '{0, 1'b0, 4'd3, 4'h0, 1, 4'hA, 4};
      vt[1] = '{1, 1'b1, 4'd7, 4'h5, 1, 4'hA, 4};
      vt[2] = '{1, 1'b0, 4'd7, 4'h0, 1, 4'h5, 4};
      vt[3] = '{0, 1'b1, 4'd2, 4'hC, 4, 4'h5, 7};
      vt[4] = '{0, 1'b0, 4'd2, 4'h0, 4, 4'hC, 7};
      vt[5] = '{1, 1'b0, 4'd3, 4'h0, 2, 4'hA, 5};

      #1;
      chk("rst_psel", 32'(psel), 0);
      chk("rst_penable", 32'(penable), 0);
      chk("rst_pwrite", 32'(pwrite), 0);
      chk("rst_paddr", 32'(paddr), 0);
      chk("rst_pwdata", 32'(pwdata), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_err", 32'(err), 0);
      do_reset();

      for (int v = 0; v < 6; v++) begin
         xfer(vt[v].idx, vt[v].wr, vt[v].addr, vt[v].wd, vt[v].k,
              lat, rd, er, dn, st, pen);
         chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vt[v].exp_lat));
         chk($sformatf("v%0d_done", v), 32'(dn), 32'(1 << vt[v].idx));
         chk($sformatf("v%0d_rdata", v), 32'(rd), 32'(vt[v].exp_rd));
         chk($sformatf("v%0d_err", v), 32'(er), 0);
         chk($sformatf("v%0d_stable", v), 32'(st), 1);
         chk($sformatf("v%0d_penable", v), 32'(pen), 32'(vt[v].k + 1));
      end
      chk("mem7", 32'(mem[7]), 32'h5);
      chk("mem2", 32'(mem[2]), 32'hC);

      // Contention: both requesters issue 3 writes each
      do_reset();
      kwait = 1;
      cnt[0] = 0; cnt[1] = 0; seen = 0;
      req_write = 2'b11;
      req_addr = {4'd12, 4'd8};
      req_wdata = {4'hD, 4'h1};
      req = 2'b11;
      prev_psel = 1'b0; gap = 0; ngap = 0;
      for (int c = 0; c < 200 && seen < 6; c++) begin
         @(posedge pclk); #1;
         if (!psel) gap++;
         if (psel && !prev_psel && seen > 0) begin
            chk("cont_gap", 32'(gap), 1);
            ngap++;
         end
         if (psel) gap = 0;
         prev_psel = psel;
         for (int j = 0; j < 2; j++) begin
            if (done[j]) begin
               ord[seen] = j;
               seen++;
               cnt[j]++;
               req_addr[j*4 +: 4] = req_addr[j*4 +: 4] + 4'd1;
               req_wdata[j*4 +: 4] = (j == 0) ? req_wdata[3:0] + 4'd1
                                              : req_wdata[7:4] - 4'd1;
               if (cnt[j] == 3) req[j] = 1'b0;
            end
         end
      end
      chk("cont_count", 32'(seen), 6);
      chk("cont_gaps", 32'(ngap), 5);
      for (int i = 0; i < 6; i++)
         chk($sformatf("cont_ord%0d", i), 32'(ord[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("cont_m0_%0d", i), 32'(mem[8+i]), 32'(1 + i));
         chk($sformatf("cont_m1_%0d", i), 32'(mem[12+i]), 32'(13 - i));
      end
      @(posedge pclk); #1;

      // Reset mid-ACCESS: ptr must return to 0
      xfer(0, 1'b0, 4'd3, 4'h0, 1, lat, rd, er, dn, st, pen);
      chk("pre_rst_done", 32'(dn), 32'h1);
      kwait = 20;
      req_write = 2'b00;
      req_addr = {4'd7, 4'd3};
      req = 2'b10;
      seen = 0;
      for (int c = 0; c < 20 && !penable; c++) begin
         @(posedge pclk); #1;
      end
      chk("mid_penable", 32'(penable), 1);
      presetn = 1'b0;
      #1;
      chk("mid_rst_outs",
          32'({psel, penable, pwrite, paddr, pwdata, done, rdata, err}), 0);
      req = 2'b11;
      kwait = 1;
      repeat (2) begin
         @(posedge pclk); #1;
         if (|done) seen++;
      end
      presetn = 1'b1;
      chk("mid_rst_nodone", 32'(seen), 0);
      dn = '0;
      for (int c = 0; c < 30; c++) begin
         @(posedge pclk); #1;
         if (|done) begin dn = done; break; end
      end
      chk("post_rst_first", 32'(dn), 32'h1);
      req[0] = 1'b0;
      dn = '0;
      for (int c = 0; c < 30; c++) begin
         @(posedge pclk); #1;
         if (|done) begin dn = done; rd = rdata; break; end
      end
      chk("post_rst_second", 32'(dn), 32'h2);
      chk("post_rst_rdata", 32'(rd), 32'h5);
      req = 2'b00;
      @(posedge pclk); #1;

`ifdef APB_RR_TIMEOUT_EN
      // Timeout with pready held low, then requester 1 is served
      do_reset();
      kwait = 1000;
      req_write = 2'b00;
      req_addr = {4'd7, 4'd3};
      req = 2'b11;
      lat = 0; dn = '0; er = 1'b0; rd = 4'hF;
      for (int c = 1; c < 30; c++) begin
         @(posedge pclk); #1;
         if (|done) begin lat = c; dn = done; er = err; rd = rdata; break; end
      end
      chk("tmo_lat", 32'(lat), 6);
      chk("tmo_done", 32'(dn), 32'h1);
      chk("tmo_err", 32'(er), 1);
      chk("tmo_rdata", 32'(rd), 0);
      req[0] = 1'b0;
      kwait = 1;
      dn = '0; er = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge pclk); #1;
         if (|done) begin dn = done; er = err; break; end
      end
      chk("tmo_next", 32'(dn), 32'h2);
      chk("tmo_next_err", 32'(er), 0);
      req = 2'b00;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
